// File: rtl/policy_deck_shuffler.sv
// In-place Fisher-Yates shuffle of the low `count` deck bits, driven by a 16-bit Galois LFSR with rejection sampling.
// Optional SHUFFLE_ENTROPY_EN mixes entropy_in into the LFSR stream.
module policy_deck_shuffler #(
    parameter int unsigned N_CARDS   = 17,
    parameter int unsigned CNT_W     = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_CARDS-1:0] deck_in,
    input  logic [CNT_W-1:0]   count_in,
    input  logic               entropy_in,
    output logic               busy,
    output logic               done,
    output logic               valid,
    output logic [N_CARDS-1:0] deck_out
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [N_CARDS-1:0] deck_q, deck_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [15:0]        lfsr_q, lfsr_d, lfsr_step;
    logic [CNT_W-1:0]   cand;
    logic [CNT_W-1:0]   n_clamp;

    assign cand    = lfsr_q[CNT_W-1:0];
    assign n_clamp = (count_in > CNT_W'(N_CARDS)) ? CNT_W'(N_CARDS) : count_in;

    always_comb begin
        lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

`ifdef SHUFFLE_ENTROPY_EN
    logic [15:0] lfsr_mix;

    // Entropy can drive the register to zero, so reseed rather than lock up.
    always_comb begin
        lfsr_mix = lfsr_step ^ {15'd0, entropy_in};
        lfsr_d   = (lfsr_mix == '0) ? LFSR_SEED : lfsr_mix;
    end
`else
    logic unused_entropy;

    assign unused_entropy = entropy_in;
    assign lfsr_d         = lfsr_step;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            deck_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            deck_q  <= deck_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        deck_d  = deck_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    deck_d  = deck_in;
                    idx_d   = (n_clamp == '0) ? '0 : n_clamp - 1'b1;
                    valid_d = 1'b0;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (idx_q == '0) begin
                    state_d = S_FIN;
                end else if (cand <= idx_q) begin
                    deck_d[idx_q] = deck_q[cand];
                    deck_d[cand]  = deck_q[idx_q];
                    idx_d         = idx_q - 1'b1;
                end
            end
            S_FIN: begin
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_FIN);
    end

    assign valid    = valid_q;
    assign deck_out = deck_q;

endmodule

// File: tb/tb_policy_deck_shuffler.sv
// Self-checking bench for policy_deck_shuffler: algorithmic Fisher-Yates reference driven by a free-running LFSR copy.
module tb_policy_deck_shuffler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [16:0] deck_in;
    logic [4:0]  count_in;
    logic        entropy_in;
    logic        busy;
    logic        done;
    logic        valid;
    logic [16:0] deck_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] lfsr_m;

    policy_deck_shuffler #(
        .N_CARDS  (17),
        .CNT_W    (5),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .deck_in   (deck_in),
        .count_in  (count_in),
        .entropy_in(entropy_in),
        .busy      (busy),
        .done      (done),
        .valid     (valid),
        .deck_out  (deck_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] adv(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference random stream: seeded by reset, one step per non-reset clock.
    always @(posedge clk) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= adv(lfsr_m);
    end

    task automatic model_shuffle(input logic [16:0] d, input int unsigned cnt,
                                 input logic [15:0] seed,
                                 output logic [16:0] od, output int unsigned draws);
        int unsigned n;
        logic [15:0] l;
        int j;
        logic b;
        n = (cnt > 17) ? 17 : cnt;
        l = seed;
        od = d;
        draws = 0;
        for (int i = int'(n) - 1; i >= 1; i--) begin
            do begin
                j = int'(l[4:0]);
                l = adv(l);
                draws++;
            end while (j > i);
            b = od[i];
            od[i] = od[j];
            od[j] = b;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_shuffle(input string name, input logic [16:0] d,
                               input logic [4:0] cnt, input bit hold);
        logic [16:0] exp_deck;
        int unsigned draws;
        int unsigned n;
        int unsigned cyc;
        n = (cnt > 17) ? 17 : cnt;
        start = 1'b1;
        deck_in = d;
        count_in = cnt;
        step();
        if (!hold) start = 1'b0;
        model_shuffle(d, cnt, lfsr_m, exp_deck, draws);
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            checks++;
            if (busy !== 1'b1 || valid !== 1'b0)
                begin errors++; $display("FAIL %s busy_valid: got busy=%b valid=%b expected 1/0", name, busy, valid); end
            checks++;
            if ($countones(deck_out) != $countones(d))
                begin errors++; $display("FAIL %s popcount: got %0d expected %0d", name, $countones(deck_out), $countones(d)); end
            checks++;
            if ((deck_out >> n) !== (d >> n))
                begin errors++; $display("FAIL %s upper_bits: got %h expected %h", name, deck_out >> n, d >> n); end
            deck_in = 17'($urandom);
            count_in = 5'($urandom);
            entropy_in = 1'($urandom);
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: got no done after %0d cycles expected done", name, cyc);
            start = 1'b0;
            return;
        end
        checks++;
        if (cyc != draws + 1)
            begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, draws + 1); end
        checks++;
        if (deck_out !== exp_deck || busy !== 1'b1)
            begin errors++; $display("FAIL %s deck: got %h busy=%b expected %h busy=1", name, deck_out, busy, exp_deck); end
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || valid !== 1'b1 || busy !== 1'b0 || deck_out !== exp_deck)
            begin errors++; $display("FAIL %s post_done: got done=%b valid=%b busy=%b deck=%h expected 0/1/0/%h",
                                     name, done, valid, busy, deck_out, exp_deck); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        deck_in = '0;
        count_in = '0;
        entropy_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0 || deck_out !== 17'h0)
            begin errors++; $display("FAIL reset: got busy=%b done=%b valid=%b deck=%h expected 0/0/0/00000",
                                     busy, done, valid, deck_out); end
    endtask

    task automatic test_golden();
        run_shuffle("golden_3F", 17'h0003F, 5'd17, 1'b0);
        checks++;
        if ($countones(deck_out) != 6)
            begin errors++; $display("FAIL golden_pop: got %0d expected 6", $countones(deck_out)); end
    endtask

    task automatic test_uniform();
        run_shuffle("all_ones", 17'h1FFFF, 5'd10, 1'b0);
        checks++;
        if (deck_out !== 17'h1FFFF)
            begin errors++; $display("FAIL all_ones_val: got %h expected 1ffff", deck_out); end
        run_shuffle("all_zeros", 17'h00000, 5'd10, 1'b0);
        checks++;
        if (deck_out !== 17'h00000)
            begin errors++; $display("FAIL all_zeros_val: got %h expected 00000", deck_out); end
    endtask

    task automatic test_small_count();
        run_shuffle("count1", 17'h00155, 5'd1, 1'b0);
        checks++;
        if (deck_out !== 17'h00155)
            begin errors++; $display("FAIL count1_val: got %h expected 00155", deck_out); end
        step();
        run_shuffle("count0", 17'h00155, 5'd0, 1'b0);
        checks++;
        if (deck_out !== 17'h00155)
            begin errors++; $display("FAIL count0_val: got %h expected 00155", deck_out); end
    endtask

    task automatic test_high_bits();
        run_shuffle("high_bits", 17'h1F000, 5'd8, 1'b0);
        checks++;
        if (deck_out[16:8] !== 9'b111110000)
            begin errors++; $display("FAIL high_bits_val: got %b expected 111110000", deck_out[16:8]); end
    endtask

    task automatic test_clamp();
        run_shuffle("clamp31", 17'h0003F, 5'd31, 1'b0);
        checks++;
        if ($countones(deck_out) != 6)
            begin errors++; $display("FAIL clamp_pop: got %0d expected 6", $countones(deck_out)); end
    endtask

    task automatic test_start_hold();
        run_shuffle("start_hold", 17'h0A5A5, 5'd17, 1'b1);
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL hold_idle: got busy=%b done=%b expected 0/0", busy, done); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 4)) step();
            run_shuffle("random", 17'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        deck_in = 17'h0F0F0;
        count_in = 5'd17;
        step();
        start = 1'b0;
        repeat (3) step();
        checks++;
        if (busy !== 1'b1)
            begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || deck_out !== 17'h0 || done !== 1'b0)
            begin errors++; $display("FAIL mid_reset: got busy=%b valid=%b deck=%h done=%b expected 0/0/00000/0",
                                     busy, valid, deck_out, done); end
        rst = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL mid_after: got done=%b busy=%b expected 0/0", done, busy); end
        run_shuffle("after_reset", 17'h0003F, 5'd17, 1'b0);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_uniform();
        test_small_count();
        test_high_bits();
        test_clamp();
        test_start_hold();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
